// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, writeback producer indices and the
// producer-side writeback request type.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_CSR = 2;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: round-robin from a rotating pointer (RR != 0) or fixed
// priority with the lowest index winning (RR == 0).
module rr_arbiter #(
    parameter int N  = 3,
    parameter int RR = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req_i,
    input  logic         adv_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int unsigned   win;

    // Scan outward from the pointer; the first requester encountered wins.
    always_comb begin
        found = 1'b0;
        win   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req_i[i] && (((32'(ptr_q) + k) % N) == i)) begin
                    found = 1'b1;
                    win   = i;
                end
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            gnt_o[i] = found && (win == i);
        end
    end

    // Kept apart from the grant logic so the advance strobe, which is derived
    // from the grant, does not close a combinational loop through one block.
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = PW'((win + 1) % N);
        end
    end

    generate
        if (RR != 0) begin : g_rr
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= ptr_d;
                end
            end
        end else begin : g_fixed
            assign ptr_q = '0;
        end
    endgenerate

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback stage: arbitrates NUM_SRC producers onto one
// registered write port, dropping x0 writes. WRITEBACK_RETIRE_EN adds a 64-bit retired counter.
module writeback_arbiter #(
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int REG_AW  = cpu_pkg::REG_AW,
    parameter int NUM_SRC = 3,
    parameter int ARB_RR  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]   src_data,
    input  logic                      hold,
    output logic                      wen,
    output logic [REG_AW-1:0]         waddr,
    output logic [XLEN-1:0]           wdata
`ifdef WRITEBACK_RETIRE_EN
    ,
    output logic [63:0]               retired
`endif
);

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] gnt;
    logic               xfer;
    logic [REG_AW-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_data;

    logic               wen_q,   wen_d;
    logic [REG_AW-1:0]  waddr_q, waddr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;

    // Requests are masked by hold and by reset so no grant escapes during reset.
    assign req = src_valid & {NUM_SRC{~hold & reset}};

    rr_arbiter #(
        .N  (NUM_SRC),
        .RR (ARB_RR)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .adv_i (xfer),
        .gnt_o (gnt)
    );

    assign src_ready = gnt;
    assign xfer      = |gnt;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            sel_rd   = sel_rd   | (src_rd[i*REG_AW +: REG_AW] & {REG_AW{gnt[i]}});
            sel_data = sel_data | (src_data[i*XLEN +: XLEN]   & {XLEN{gnt[i]}});
        end
    end

    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (xfer && (sel_rd != '0)) begin
            wen_d   = 1'b1;
            waddr_d = sel_rd;
            wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wen   = wen_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

`ifdef WRITEBACK_RETIRE_EN
    logic [63:0] retired_q, retired_d;

    // x0 transfers are still accepted, so they count as retired.
    assign retired_d = retired_q + 64'(xfer);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: a round-robin and a fixed-priority instance share
// stimulus and are compared against a queue-free behavioural model.
module tb_writeback_arbiter;
    import cpu_pkg::*;

    localparam int N = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                hold;
    logic [N-1:0]        src_valid;
    wb_req_t             req [N];
    logic [N*REG_AW-1:0] src_rd;
    logic [N*XLEN-1:0]   src_data;

    logic [N-1:0]        ready_a, ready_b;
    logic                wen_a, wen_b;
    logic [REG_AW-1:0]   waddr_a, waddr_b;
    logic [XLEN-1:0]     wdata_a, wdata_b;
`ifdef WRITEBACK_RETIRE_EN
    logic [63:0]         retired_a, retired_b;
`endif

    assign src_rd   = {req[2].rd, req[1].rd, req[0].rd};
    assign src_data = {req[2].data, req[1].data, req[0].data};

    always #5 clk = ~clk;

    writeback_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(N), .ARB_RR(1)) dut_a (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(ready_a),
        .src_rd(src_rd), .src_data(src_data), .hold(hold),
        .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a)
`ifdef WRITEBACK_RETIRE_EN
        , .retired(retired_a)
`endif
    );

    writeback_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_SRC(N), .ARB_RR(0)) dut_b (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(ready_b),
        .src_rd(src_rd), .src_data(src_data), .hold(hold),
        .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b)
`ifdef WRITEBACK_RETIRE_EN
        , .retired(retired_b)
`endif
    );

    int                n_vec = 0;
    int                n_err = 0;
    int                ptr_a;
    int                ga, gb;
    logic [N-1:0]      exp_rdy_a, exp_rdy_b;
    logic              exp_wen_a, exp_wen_b;
    logic [REG_AW-1:0] exp_waddr_a, exp_waddr_b;
    logic [XLEN-1:0]   exp_wdata_a, exp_wdata_b;
    logic [63:0]       exp_ret_a, exp_ret_b;

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ptr_a = 0;
        exp_wen_a = 1'b0; exp_waddr_a = '0; exp_wdata_a = '0; exp_ret_a = '0;
        exp_wen_b = 1'b0; exp_waddr_b = '0; exp_wdata_b = '0; exp_ret_b = '0;
    endtask

    // Let inputs settle and work out who should be granted this cycle.
    task automatic settle();
        #1;
        if (!reset || hold) begin
            ga = -1;
            gb = -1;
        end else begin
            ga = pick(src_valid, ptr_a);
            gb = pick(src_valid, 0);
        end
        for (int i = 0; i < N; i++) begin
            exp_rdy_a[i] = (i == ga);
            exp_rdy_b[i] = (i == gb);
        end
    endtask

    // Apply this cycle's transfers to the model, then advance past the edge.
    task automatic tick();
        exp_wen_a = 1'b0;
        exp_wen_b = 1'b0;
        if (ga >= 0) begin
            ptr_a     = (ga + 1) % N;
            exp_ret_a = exp_ret_a + 64'd1;
            if (req[ga].rd != '0) begin
                exp_wen_a = 1'b1; exp_waddr_a = req[ga].rd; exp_wdata_a = req[ga].data;
            end
        end
        if (gb >= 0) begin
            exp_ret_b = exp_ret_b + 64'd1;
            if (req[gb].rd != '0) begin
                exp_wen_b = 1'b1; exp_waddr_b = req[gb].rd; exp_wdata_b = req[gb].data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({wen_a, waddr_a, wdata_a, wen_b, waddr_b, wdata_b} !== '0) begin
            n_err++;
            $display("FAIL reset_init got wen=%b waddr=%h wdata=%h required 0/0/0", wen_a, waddr_a, wdata_a);
        end
        reset = 1'b1;
        src_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            req[i].rd = REG_AW'(i + 1);
            req[i].data = $urandom;
        end
        settle();
        tick();
        settle();
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({wen_a, waddr_a, wdata_a, wen_b, waddr_b, wdata_b} !== '0 || ready_a !== '0 || ready_b !== '0) begin
            n_err++;
            $display("FAIL reset_mid got wen=%b waddr=%h wdata=%h rdy=%b required 0/0/0/000", wen_a, waddr_a, wdata_a, ready_a);
        end
`ifdef WRITEBACK_RETIRE_EN
        n_vec++;
        if (retired_a !== 64'd0 || retired_b !== 64'd0) begin
            n_err++;
            $display("FAIL reset_retired got %0d required 0", retired_a);
        end
`endif
        @(posedge clk);
        #1;
        n_vec++;
        if (ready_a !== '0 || ready_b !== '0 || wen_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held got rdy=%b wen=%b required 000/0", ready_a, wen_a);
        end
        reset = 1'b1;
    endtask

    task automatic test_rr_rotation();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        logic [N-1:0] onehot;
        src_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            settle();
            onehot = 3'b001 << order[c];
            n_vec++;
            if (ready_a !== onehot || ready_a !== exp_rdy_a || ready_b !== 3'b001) begin
                n_err++;
                $display("FAIL rr_grant[%0d] got a=%b b=%b required a=%b b=001", c, ready_a, ready_b, onehot);
            end
            tick();
            n_vec++;
            if (wen_a !== 1'b1 || waddr_a !== REG_AW'(order[c] + 1) || wdata_a !== exp_wdata_a) begin
                n_err++;
                $display("FAIL rr_waddr[%0d] got wen=%b waddr=%0d wdata=%h required 1/%0d/%h",
                         c, wen_a, waddr_a, wdata_a, order[c] + 1, exp_wdata_a);
            end
        end
        src_valid = '0;
    endtask

    task automatic test_single_write();
        src_valid = 3'b010;
        req[1].rd = 5'd5;
        req[1].data = 32'hDEADBEEF;
        settle();
        n_vec++;
        if (ready_a !== 3'b010 || ready_b !== 3'b010) begin
            n_err++;
            $display("FAIL single_ready got a=%b b=%b required 010", ready_a, ready_b);
        end
        tick();
        src_valid = '0;
        n_vec++;
        if ({wen_a, waddr_a, wdata_a} !== {1'b1, 5'd5, 32'hDEADBEEF} ||
            {wen_b, waddr_b, wdata_b} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL single_write got wen=%b waddr=%0d wdata=%h required 1/5/deadbeef", wen_a, waddr_a, wdata_a);
        end
        settle();
        tick();
        n_vec++;
        if (wen_a !== 1'b0 || wen_b !== 1'b0 || waddr_a !== 5'd5) begin
            n_err++;
            $display("FAIL single_pulse got wen=%b waddr=%0d required 0/5", wen_a, waddr_a);
        end
    endtask

    task automatic test_x0_suppress();
        src_valid = 3'b001;
        req[0].rd = '0;
        req[0].data = 32'h1234;
        settle();
        n_vec++;
        if (ready_a !== 3'b001 || ready_b !== 3'b001) begin
            n_err++;
            $display("FAIL x0_ready got a=%b b=%b required 001", ready_a, ready_b);
        end
        tick();
        src_valid = '0;
        n_vec++;
        if ({wen_a, waddr_a, wdata_a} !== {1'b0, 5'd5, 32'hDEADBEEF} ||
            {wen_b, waddr_b, wdata_b} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL x0_hold got wen=%b waddr=%0d wdata=%h required 0/5/deadbeef", wen_a, waddr_a, wdata_a);
        end
`ifdef WRITEBACK_RETIRE_EN
        n_vec++;
        if (retired_a !== exp_ret_a || retired_b !== exp_ret_b) begin
            n_err++;
            $display("FAIL x0_retired got %0d required %0d", retired_a, exp_ret_a);
        end
`endif
    endtask

    task automatic test_fixed_priority();
        src_valid = 3'b101;
        req[0].rd = 5'd7;
        req[0].data = $urandom;
        req[2].rd = 5'd9;
        req[2].data = $urandom;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++;
            if (ready_b !== 3'b001 || ready_a !== exp_rdy_a) begin
                n_err++;
                $display("FAIL fixed_grant[%0d] got b=%b a=%b required b=001 a=%b", c, ready_b, ready_a, exp_rdy_a);
            end
            tick();
            n_vec++;
            if ({wen_b, waddr_b, wdata_b} !== {1'b1, 5'd7, req[0].data} ||
                {wen_a, waddr_a, wdata_a} !== {exp_wen_a, exp_waddr_a, exp_wdata_a}) begin
                n_err++;
                $display("FAIL fixed_write[%0d] got b=%b/%0d a=%b/%0d required b=1/7 a=%b/%0d",
                         c, wen_b, waddr_b, wen_a, waddr_a, exp_wen_a, exp_waddr_a);
            end
        end
        src_valid = '0;
    endtask

    task automatic test_hold();
        src_valid = 3'b100;
        req[2].rd = 5'd11;
        req[2].data = $urandom;
        hold = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            n_vec++;
            if (ready_a !== '0 || ready_b !== '0 || wen_a !== exp_wen_a || waddr_a !== exp_waddr_a) begin
                n_err++;
                $display("FAIL hold_block[%0d] got rdy=%b/%b wen=%b waddr=%0d required 000/000 %b/%0d",
                         c, ready_a, ready_b, wen_a, waddr_a, exp_wen_a, exp_waddr_a);
            end
            tick();
            n_vec++;
            if (wen_a !== 1'b0 || wen_b !== 1'b0) begin
                n_err++;
                $display("FAIL hold_wen[%0d] got %b/%b required 0", c, wen_a, wen_b);
            end
        end
        hold = 1'b0;
        settle();
        n_vec++;
        if (ready_a !== 3'b100 || ready_b !== 3'b100) begin
            n_err++;
            $display("FAIL hold_release got a=%b b=%b required 100", ready_a, ready_b);
        end
        tick();
        src_valid = '0;
        n_vec++;
        if ({wen_a, waddr_a, wen_b, waddr_b} !== {1'b1, 5'd11, 1'b1, 5'd11}) begin
            n_err++;
            $display("FAIL hold_write got wen=%b waddr=%0d required 1/11", wen_a, waddr_a);
        end
    endtask

    task automatic test_random();
        int wait_cnt [N] = '{0, 0, 0};
        for (int c = 0; c < 400; c++) begin
            // Producers keep an unaccepted request (w.r.t. the round-robin instance) stable.
            for (int i = 0; i < N; i++) begin
                if (!(src_valid[i] && ga != i)) begin
                    src_valid[i] = ($urandom_range(0, 2) != 0);
                    req[i].rd = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
                    req[i].data = $urandom;
                end
            end
            hold = ($urandom_range(0, 4) == 0);
            settle();
            n_vec++;
            if (ready_a !== exp_rdy_a || ready_b !== exp_rdy_b) begin
                n_err++;
                $display("FAIL rand_ready[%0d] got a=%b b=%b required a=%b b=%b", c, ready_a, ready_b, exp_rdy_a, exp_rdy_b);
            end
            for (int i = 0; i < N; i++) begin
                if (ready_a[i]) wait_cnt[i] = 0;
                else if (src_valid[i] && !hold) wait_cnt[i]++;
                n_vec++;
                if (wait_cnt[i] >= N) begin
                    n_err++;
                    $display("FAIL rand_fair[%0d] ch%0d waited %0d non-hold cycles required <%0d", c, i, wait_cnt[i], N);
                end
            end
            tick();
            n_vec++;
            if ({wen_a, waddr_a, wdata_a} !== {exp_wen_a, exp_waddr_a, exp_wdata_a} ||
                {wen_b, waddr_b, wdata_b} !== {exp_wen_b, exp_waddr_b, exp_wdata_b}) begin
                n_err++;
                $display("FAIL rand_write[%0d] got a=%b/%0d/%h b=%b/%0d/%h required a=%b/%0d/%h b=%b/%0d/%h", c,
                         wen_a, waddr_a, wdata_a, wen_b, waddr_b, wdata_b,
                         exp_wen_a, exp_waddr_a, exp_wdata_a, exp_wen_b, exp_waddr_b, exp_wdata_b);
            end
`ifdef WRITEBACK_RETIRE_EN
            n_vec++;
            if (retired_a !== exp_ret_a || retired_b !== exp_ret_b) begin
                n_err++;
                $display("FAIL rand_retired[%0d] got %0d/%0d required %0d/%0d", c, retired_a, retired_b, exp_ret_a, exp_ret_b);
            end
`endif
        end
        hold = 1'b0;
        src_valid = '0;
    endtask

    initial begin
        reset = 1'b1;
        hold = 1'b0;
        src_valid = '0;
        ga = -1;
        gb = -1;
        for (int i = 0; i < N; i++) req[i] = '0;
        model_reset();
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rr_rotation();
        test_single_write();
        test_x0_suppress();
        test_fixed_priority();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

- Parametrised register-file writeback stage for the little CPU; replaces the single-source writeback.
- Accepts results from `NUM_SRC` producers (ALU, LSU, CSR, …) over valid/ready handshakes.
- Arbitrates among them (round-robin or fixed priority), suppresses writes to x0, and drives one registered register-file write port.
- Optionally keeps a retired-instruction counter.

## Interface

Parameters:
- `XLEN`, 32, data width of results and of `wdata`
- `REG_AW`, 5, register address width
- `NUM_SRC`, 3, number of producer channels (≥1)
- `ARB_RR`, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `src_valid`  in  `NUM_SRC`  producer i has a result
- `src_ready`  out  `NUM_SRC`  producer i's result is accepted this cycle
- `src_rd`  in  `NUM_SRC`×`REG_AW`  destination register per producer
- `src_data`  in  `NUM_SRC`×`XLEN`  result data per producer
- `hold`  in  1  register file busy; no grant this cycle
- `wen`  out  1  register-file write enable, one-cycle pulse
- `waddr`  out  `REG_AW`  register-file write address
- `wdata`  out  `XLEN`  register-file write data
- `retired`  out  64  accepted-result count (only with `WRITEBACK_RETIRE_EN`)

## Operation

- **Grant:** each cycle, at most one channel is granted, chosen among channels with `src_valid`=1.
  - No grant when `hold`=1 or no channel is valid.
- **Ready:** `src_ready[i]` = grant[i], combinational from `src_valid`, `hold` and the arbiter state.
  - `src_ready[i]` is never 1 while `src_valid[i]`=0.
  - Transfer on channel i occurs when `src_valid[i]` & `src_ready[i]`.
- **Producer rule:** a producer holds `src_rd` and `src_data` stable while valid and not ready. The block does not buffer unaccepted requests.
- **Round-robin (`ARB_RR`=1):**
  - Pointer `ptr` ranges over 0..`NUM_SRC`-1 and is 0 at reset.
  - The search starts at `ptr` and wraps modulo `NUM_SRC`; the first valid channel wins.
  - On a transfer, `ptr` becomes winner+1, wrapping from `NUM_SRC`-1 to 0.
  - `ptr` is unchanged when there is no transfer.
- **Fixed priority (`ARB_RR`=0):** the lowest valid index wins; there is no pointer state.
- **Register the transfer:** on a transfer from channel i, at the next edge:
  - If `src_rd[i]`≠0: `wen`←1, `waddr`←`src_rd[i]`, `wdata`←`src_data[i]`.
  - If `src_rd[i]`=0 (x0): the transfer is still accepted, but `wen`←0 and `waddr`/`wdata` hold their previous values.
- **No transfer:** `wen`←0; `waddr`/`wdata` hold.
- **Single channel (`NUM_SRC`=1):** degenerates to a pass-through register with `src_ready[0]` = `src_valid[0]` & ~`hold`.

## Timing

- **Reset values:** `wen`=0, `waddr`=0, `wdata`=0, `ptr`=0, `retired`=0. All `src_ready` are 0 while `reset`=0.
- **Reset assertion:** asynchronous and takes effect mid-cycle. Any transfer in that cycle is lost and is not counted.
- **Deassertion:** the first grant is possible in the first cycle after `reset` rises.
- **Latency:** transfer in cycle N gives `wen`/`waddr`/`wdata` visible in cycle N+1. `wen` is high for exactly one cycle per non-x0 transfer.
- **Throughput:** one transfer per cycle. Back-to-back transfers give `wen` high continuously.
- **`hold`:**
  - Takes effect combinationally in the same cycle and blocks that cycle's transfer.
  - The write registered in the previous cycle is still presented; the register file must accept it.
- **Simultaneous valids:** exactly one winner per cycle. The losers keep `src_ready`=0 and retry.
- **Fairness under round-robin:** a continuously valid channel is granted within `NUM_SRC` non-`hold` cycles.

## Configuration

- **Macro:** `WRITEBACK_RETIRE_EN`.
- **Defined:**
  - A 64-bit `retired` counter increments by 1 on every transfer, including x0 transfers.
  - It wraps from 2^64-1 to 0 and resets to 0.
  - `retired` reflects transfers up to and including the previous cycle, i.e. it is updated on the same edge as `wen`.
- **Undefined:** the `retired` port and the counter are absent. All other behaviour is identical.

## Structure

- **Shared package `cpu_pkg`:**
  - `XLEN`, `REG_AW`.
  - Producer index constants `SRC_ALU`=0, `SRC_LSU`=1, `SRC_CSR`=2.
  - Typedef `wb_req_t` {rd, data} used by producers.
- **Sub-module `rr_arbiter`:**
  - Parameters `N` and `RR`.
  - Inputs: request vector, advance strobe. Output: one-hot grant.
  - Owns `ptr`, with async active-low reset.
- **Top level:** one-hot mux of `src_rd`/`src_data`, x0 filter, output register, optional counter.

## Test plan

- **Reset:** assert `reset`=0 mid-stream with `src_valid`=3'b111. Required: `wen`=0, `waddr`=0, `wdata`=0 and `src_ready`=0 immediately; `retired`=0.
- **Single write:** ch1 valid, rd=5, data=0xDEADBEEF. Required: `src_ready[1]`=1 the same cycle; next cycle `wen`=1, `waddr`=5, `wdata`=0xDEADBEEF; the following cycle `wen`=0.
- **x0 suppression:** ch0 rd=0, data=0x1234. Required: `src_ready[0]`=1 and `wen` stays 0; `waddr`/`wdata` unchanged; `retired` +1 with the macro defined.
- **Round-robin rotation:** `ARB_RR`=1, `NUM_SRC`=3, all three valid for 6 cycles, rd=1/2/3. Required: grant order 0,1,2,0,1,2 and `waddr` sequence 1,2,3,1,2,3 one cycle later.
- **Fixed priority:** `ARB_RR`=0, ch0 and ch2 valid for 3 cycles. Required: ch0 granted all 3 cycles and ch2 `src_ready` stays 0.
- **`hold`:** ch2 valid, `hold`=1 for 2 cycles, then 0. Required: no `src_ready` and `wen`=0 during `hold`; a grant on the first cycle `hold`=0; `wen`=1 the cycle after.
